// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage MIPS pipeline.
// Holds the EX/MEM pipeline register, RS/RT forwarding muxes, ALU control,
// the ALU, and the multiplier used by `mul`.
// Build option EX_ITER_MUL_EN: when defined, `mul` runs on a 32-iteration
// shift-add multiplier that stalls the front of the pipeline; when undefined,
// `mul` is a single-cycle combinational product and stall_o is tied low.
module ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        Memory_write_i,
  input  logic        Memory_read_i,
  input  logic        ALUSrc_i,
  input  logic        RegDst_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [31:0] RSdata_i,
  input  logic [31:0] RTdata_i,
  input  logic [31:0] Sign_extend_i,
  input  logic [4:0]  RSaddr_i,
  input  logic [4:0]  RTaddr_i,
  input  logic [4:0]  RDaddr_i,
  input  logic [5:0]  funct_i,
  input  logic        MEMWB_RegWrite_i,
  input  logic [4:0]  MEMWB_addr_i,
  input  logic [31:0] MEMWB_data_i,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        Memory_write_o,
  output logic        Memory_read_o,
  output logic [31:0] ALUresult_o,
  output logic [31:0] WriteData_o,
  output logic [4:0]  WBaddr_o,
  output logic        stall_o
);

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  logic [31:0] fwd_a;
  logic [31:0] fwd_rt;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic [31:0] mul_result;
  logic [4:0]  wb_addr;
  logic        mul_present;

  assign mul_present = (ALUOp_i == 2'b10) && (funct_i == FUNCT_MUL);
  assign op_b        = ALUSrc_i ? Sign_extend_i : fwd_rt;
  assign wb_addr     = RegDst_i ? RDaddr_i : RTaddr_i;

  // Forwarding: the younger EX/MEM result wins over MEM/WB; r0 never forwards.
  always_comb begin
    fwd_a  = RSdata_i;
    fwd_rt = RTdata_i;
    if (RegWrite_o && (WBaddr_o != 5'd0) && (WBaddr_o == RSaddr_i))
      fwd_a = ALUresult_o;
    else if (MEMWB_RegWrite_i && (MEMWB_addr_i != 5'd0) && (MEMWB_addr_i == RSaddr_i))
      fwd_a = MEMWB_data_i;
    if (RegWrite_o && (WBaddr_o != 5'd0) && (WBaddr_o == RTaddr_i))
      fwd_rt = ALUresult_o;
    else if (MEMWB_RegWrite_i && (MEMWB_addr_i != 5'd0) && (MEMWB_addr_i == RTaddr_i))
      fwd_rt = MEMWB_data_i;
  end

  // ALU control and ALU: ALUOp picks a fixed op, or defers to funct for R-type.
  always_comb begin
    alu_result = 32'd0;
    case (ALUOp_i)
      2'b00:   alu_result = fwd_a + op_b;
      2'b01:   alu_result = fwd_a - op_b;
      2'b11:   alu_result = fwd_a + op_b;
      default: begin
        case (funct_i)
          FUNCT_ADD: alu_result = fwd_a + op_b;
          FUNCT_SUB: alu_result = fwd_a - op_b;
          FUNCT_AND: alu_result = fwd_a & op_b;
          FUNCT_OR:  alu_result = fwd_a | op_b;
          FUNCT_MUL: alu_result = mul_result;
          default:   alu_result = 32'd0;
        endcase
      end
    endcase
  end

`ifdef EX_ITER_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mul_state_e;

  mul_state_e  state_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] product_q;
  logic [4:0]  count_q;

  // Shift-add multiplier: operands are latched on detect because the
  // forwarding sources drain while the front of the pipe is frozen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mcand_q   <= 32'd0;
      mplier_q  <= 32'd0;
      product_q <= 32'd0;
      count_q   <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mul_present) begin
            state_q   <= BUSY;
            mcand_q   <= fwd_a;
            mplier_q  <= op_b;
            product_q <= 32'd0;
            count_q   <= 5'd0;
          end
        end
        BUSY: begin
          if (mplier_q[0])
            product_q <= product_q + mcand_q;
          mcand_q  <= {mcand_q[30:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          count_q  <= count_q + 5'd1;
          if (count_q == 5'd31)
            state_q <= DONE;
        end
        // DONE always returns to IDLE so the held mul does not re-trigger.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_result = product_q;
  assign stall_o    = ((state_q == IDLE) && mul_present) || (state_q == BUSY);
`else
  assign mul_result = fwd_a * op_b;
  assign stall_o    = 1'b0;
`endif

  // EX/MEM register: a stall loads a bubble (controls cleared, data held).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      RegWrite_o     <= 1'b0;
      MemtoReg_o     <= 1'b0;
      Memory_write_o <= 1'b0;
      Memory_read_o  <= 1'b0;
      ALUresult_o    <= 32'd0;
      WriteData_o    <= 32'd0;
      WBaddr_o       <= 5'd0;
    end else if (stall_o) begin
      RegWrite_o     <= 1'b0;
      MemtoReg_o     <= 1'b0;
      Memory_write_o <= 1'b0;
      Memory_read_o  <= 1'b0;
    end else begin
      RegWrite_o     <= RegWrite_i;
      MemtoReg_o     <= MemtoReg_i;
      Memory_write_o <= Memory_write_i;
      Memory_read_o  <= Memory_read_i;
      ALUresult_o    <= alu_result;
      WriteData_o    <= fwd_rt;
      WBaddr_o       <= wb_addr;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for ex_stage with a cycle-tagged scoreboard.
// Stimulus pushes expected stall/output entries; a negedge monitor pops them.
// Expectations follow the EX_ITER_MUL_EN build selection.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        RegWrite_i, MemtoReg_i, Memory_write_i, Memory_read_i, ALUSrc_i, RegDst_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] RSdata_i, RTdata_i, Sign_extend_i;
  logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
  logic [5:0]  funct_i;
  logic        MEMWB_RegWrite_i;
  logic [4:0]  MEMWB_addr_i;
  logic [31:0] MEMWB_data_i;
  logic        RegWrite_o, MemtoReg_o, Memory_write_o, Memory_read_o;
  logic [31:0] ALUresult_o, WriteData_o;
  logic [4:0]  WBaddr_o;
  logic        stall_o;

  ex_stage dut (
    .clk_i(clk), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .Memory_write_i(Memory_write_i),
    .Memory_read_i(Memory_read_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i),
    .ALUOp_i(ALUOp_i), .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .Sign_extend_i(Sign_extend_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i), .funct_i(funct_i),
    .MEMWB_RegWrite_i(MEMWB_RegWrite_i), .MEMWB_addr_i(MEMWB_addr_i), .MEMWB_data_i(MEMWB_data_i),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .Memory_write_o(Memory_write_o),
    .Memory_read_o(Memory_read_o), .ALUresult_o(ALUresult_o), .WriteData_o(WriteData_o),
    .WBaddr_o(WBaddr_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_out;
    int          due;
    string       name;
    logic        rw, mtr, mw, mr;
    logic [31:0] alu, wd;
    logic [4:0]  wb;
    logic        stall;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Expected EX/MEM data held across bubbles.
  logic [31:0] last_alu = 32'd0, last_wd = 32'd0;
  logic [4:0]  last_wb = 5'd0;

`ifdef EX_ITER_MUL_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  // Monitor: compare every entry due in the current cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      vectors++;
      if (e.due < cyc) begin
        miscompares++;
        $display("FAIL %s: entry for cycle %0d not checked in time (now %0d)", e.name, e.due, cyc);
      end else if (!e.is_out) begin
        if (stall_o !== e.stall) begin
          miscompares++;
          $display("FAIL %s stall: got %0b want %0b (cycle %0d)", e.name, stall_o, e.stall, cyc);
        end
      end else if ({RegWrite_o, MemtoReg_o, Memory_write_o, Memory_read_o} !== {e.rw, e.mtr, e.mw, e.mr}
                   || ALUresult_o !== e.alu || WriteData_o !== e.wd || WBaddr_o !== e.wb) begin
        miscompares++;
        $display("FAIL %s out: got ctl=%b alu=%h wd=%h wb=%0d want ctl=%b alu=%h wd=%h wb=%0d (cycle %0d)",
                 e.name, {RegWrite_o, MemtoReg_o, Memory_write_o, Memory_read_o}, ALUresult_o,
                 WriteData_o, WBaddr_o, {e.rw, e.mtr, e.mw, e.mr}, e.alu, e.wd, e.wb, cyc);
      end else begin
        $display("ok   %s out: ctl=%b alu=%h wd=%h wb=%0d", e.name,
                 {RegWrite_o, MemtoReg_o, Memory_write_o, Memory_read_o}, ALUresult_o, WriteData_o, WBaddr_o);
      end
    end
  end

  task automatic set_ctrl(input logic rw, mtr, mw, mr, alusrc, regdst,
                          input logic [1:0] aluop, input logic [5:0] fn);
    RegWrite_i = rw; MemtoReg_i = mtr; Memory_write_i = mw; Memory_read_i = mr;
    ALUSrc_i = alusrc; RegDst_i = regdst; ALUOp_i = aluop; funct_i = fn;
  endtask

  task automatic set_ops(input logic [31:0] rs, input logic [4:0] rsa,
                         input logic [31:0] rt, input logic [4:0] rta,
                         input logic [31:0] imm, input logic [4:0] rda);
    RSdata_i = rs; RSaddr_i = rsa; RTdata_i = rt; RTaddr_i = rta;
    Sign_extend_i = imm; RDaddr_i = rda;
  endtask

  task automatic set_mwb(input logic we, input logic [4:0] a, input logic [31:0] d);
    MEMWB_RegWrite_i = we; MEMWB_addr_i = a; MEMWB_data_i = d;
  endtask

  task automatic set_nop();
    set_ctrl(0, 0, 0, 0, 0, 0, 2'b00, 6'h00);
    set_ops(0, 0, 0, 0, 0, 0);
    set_mwb(0, 0, 0);
  endtask

  // Issue the currently driven instruction for one cycle and queue expectations.
  task automatic step(input string name, input logic [31:0] ealu, ewd,
                      input logic [4:0] ewb, input logic estall);
    exp_t s, o;
    s.is_out = 0; s.due = cyc; s.name = name; s.stall = estall;
    s.rw = 0; s.mtr = 0; s.mw = 0; s.mr = 0; s.alu = 0; s.wd = 0; s.wb = 0;
    o = s;
    o.is_out = 1; o.due = cyc + 1;
    if (estall) begin
      o.alu = last_alu; o.wd = last_wd; o.wb = last_wb;
    end else begin
      o.rw = RegWrite_i; o.mtr = MemtoReg_i; o.mw = Memory_write_i; o.mr = Memory_read_i;
      o.alu = ealu; o.wd = ewd; o.wb = ewb;
      last_alu = ealu; last_wd = ewd; last_wb = ewb;
    end
    q.push_back(s);
    q.push_back(o);
    @(posedge clk); #1;
  endtask

  task automatic rst_step(input string name, input bit chk_stall, input logic estall);
    exp_t s, o;
    rst_i = 1'b1;
    set_nop();
    s.is_out = 0; s.due = cyc; s.name = name; s.stall = estall;
    s.rw = 0; s.mtr = 0; s.mw = 0; s.mr = 0; s.alu = 0; s.wd = 0; s.wb = 0;
    o = s;
    o.is_out = 1; o.due = cyc + 1;
    if (chk_stall) q.push_back(s);
    q.push_back(o);
    last_alu = 0; last_wd = 0; last_wb = 0;
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    set_nop();
    @(posedge clk); #1;

    rst_step("reset0", 0, 0);
    rst_step("reset1", 0, 0);
    step("post_reset", 0, 0, 0, 0);

    // add r3 = r1(5) + r2(7)
    set_ctrl(1, 0, 0, 0, 0, 1, 2'b10, 6'h20); set_ops(5, 1, 7, 2, 0, 3);
    step("add", 32'd12, 32'd7, 5'd3, 0);
    // sub r4 = r3 - r3, EX/MEM (12) beats MEM/WB (99)
    set_ctrl(1, 0, 0, 0, 0, 1, 2'b10, 6'h22); set_ops(1, 3, 2, 3, 0, 4); set_mwb(1, 3, 32'd99);
    step("dbl_hazard", 32'd0, 32'd12, 5'd4, 0);
    // add r0 = 5 + 7, then sources r0 must not forward
    set_ctrl(1, 0, 0, 0, 0, 1, 2'b10, 6'h20); set_ops(5, 1, 7, 2, 0, 0); set_mwb(0, 0, 0);
    step("add_r0", 32'd12, 32'd7, 5'd0, 0);
    set_ctrl(1, 0, 0, 0, 0, 1, 2'b10, 6'h22); set_ops(30, 0, 10, 0, 0, 5); set_mwb(1, 0, 32'd99);
    step("r0_nofwd", 32'd20, 32'd10, 5'd5, 0);
    // and with A forwarded from MEM/WB
    set_ctrl(1, 0, 0, 0, 0, 1, 2'b10, 6'h24); set_ops(0, 6, 32'hFF00, 7, 0, 8); set_mwb(1, 6, 32'hF0F0);
    step("and_mwb", 32'hF000, 32'hFF00, 5'd8, 0);
    // or with B forwarded from EX/MEM
    set_ctrl(1, 0, 0, 0, 0, 1, 2'b10, 6'h25); set_ops(32'h0F, 9, 32'hF0, 8, 0, 11); set_mwb(0, 0, 0);
    step("or_exmem_b", 32'hF00F, 32'hF000, 5'd11, 0);
    // unsupported funct
    set_ctrl(1, 0, 0, 0, 0, 1, 2'b10, 6'h2A); set_ops(1, 12, 2, 13, 0, 14);
    step("bad_funct", 32'd0, 32'd2, 5'd14, 0);
    // sw: store data forwarded from MEM/WB
    set_ctrl(0, 0, 1, 0, 1, 0, 2'b00, 6'h00); set_ops(32'h100, 15, 0, 16, 32'hFFFFFFFC, 0);
    set_mwb(1, 16, 32'hDEAD);
    step("sw", 32'hFC, 32'hDEAD, 5'd16, 0);
    // lw
    set_ctrl(1, 1, 0, 1, 1, 0, 2'b00, 6'h00); set_ops(32'h200, 17, 32'h55, 18, 32'd8, 0); set_mwb(0, 0, 0);
    step("lw", 32'h208, 32'h55, 5'd18, 0);
    // beq-style subtract
    set_ctrl(0, 0, 0, 0, 0, 0, 2'b01, 6'h00); set_ops(10, 19, 3, 20, 0, 0);
    step("sub01", 32'd7, 32'd3, 5'd20, 0);
    // addi with -1
    set_ctrl(1, 0, 0, 0, 1, 0, 2'b11, 6'h00); set_ops(1, 21, 0, 22, 32'hFFFFFFFF, 0);
    step("addi", 32'd0, 32'd0, 5'd22, 0);
    // add wraps around
    set_ctrl(1, 0, 0, 0, 0, 1, 2'b10, 6'h20); set_ops(32'h7FFFFFFF, 23, 1, 24, 0, 25);
    step("add_ovf", 32'h80000000, 32'd1, 5'd25, 0);

    // mul 0xFFFFFFFF * 3
    set_ctrl(1, 0, 0, 0, 0, 1, 2'b10, 6'h18); set_ops(32'hFFFFFFFF, 26, 3, 27, 0, 28);
    if (ITER) begin
      for (int i = 0; i < 34; i++)
        step($sformatf("mul_c%0d", i), 32'hFFFFFFFD, 32'd3, 5'd28, (i < 33));
    end else begin
      step("mul", 32'hFFFFFFFD, 32'd3, 5'd28, 0);
    end
    // consumer of the product via EX/MEM forwarding
    set_ctrl(1, 0, 0, 0, 0, 1, 2'b10, 6'h20); set_ops(0, 28, 4, 29, 0, 30);
    step("add_after_mul", 32'd1, 32'd4, 5'd30, 0);

    // mul 5 * 6 aborted by reset
    set_ctrl(1, 0, 0, 0, 0, 1, 2'b10, 6'h18); set_ops(5, 1, 6, 2, 0, 3);
    if (ITER) begin
      for (int i = 0; i < 11; i++)
        step($sformatf("mul2_c%0d", i), 32'd30, 32'd6, 5'd3, 1);
      rst_step("rst_mid_mul", 1, 1);
    end else begin
      step("mul2", 32'd30, 32'd6, 5'd3, 0);
      rst_step("rst_after_mul", 1, 0);
    end
    set_nop();
    step("nop_after_rst0", 0, 0, 0, 0);
    step("nop_after_rst1", 0, 0, 0, 0);
    step("nop_after_rst2", 0, 0, 0, 0);

    // drain with a bounded wait
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: never checked, due cycle %0d", e.name, e.due);
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline. It sits between the ID/EX pipeline register and the MEM stage and contains:
- the EX/MEM pipeline register;
- operand forwarding muxes;
- ALU control and the ALU;
- an iterative multiplier for `mul`, which stalls the front of the pipeline while it runs.

It consumes the control bits, operands and register addresses latched by ID/EX and produces the registered EX/MEM values.

## Interface
Parameters:
- none

Ports:
- `clk_i` in 1: pipeline clock, rising edge. One clock; all state is on this clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `RegWrite_i`, `MemtoReg_i`, `Memory_write_i`, `Memory_read_i`, `ALUSrc_i`, `RegDst_i` in 1 each: control bits from ID/EX.
- `ALUOp_i` in 2: ALU class from ID/EX.
- `RSdata_i`, `RTdata_i`, `Sign_extend_i` in 32 each: operands from ID/EX.
- `RSaddr_i`, `RTaddr_i`, `RDaddr_i` in 5 each: register addresses from ID/EX.
- `funct_i` in 6: R-type function field.
- `MEMWB_RegWrite_i` in 1, `MEMWB_addr_i` in 5, `MEMWB_data_i` in 32: write-back forwarding source.
- `RegWrite_o`, `MemtoReg_o`, `Memory_write_o`, `Memory_read_o` out 1 each: EX/MEM control bits.
- `ALUresult_o` out 32: EX/MEM ALU result.
- `WriteData_o` out 32: EX/MEM store data (the forwarded RT value).
- `WBaddr_o` out 5: EX/MEM destination register.
- `stall_o` out 1: combinational; freezes the PC, IF/ID and ID/EX while high.

## Operation
Forwarding (resolved separately for operand A from RS and operand B from RT):
- EX/MEM hazard: `RegWrite_o` = 1, `WBaddr_o` != 0 and `WBaddr_o` equals the source address → use `ALUresult_o`.
- Otherwise MEM/WB hazard: `MEMWB_RegWrite_i` = 1, `MEMWB_addr_i` != 0 and `MEMWB_addr_i` equals the source address → use `MEMWB_data_i`.
- Otherwise use the ID/EX data.
- Register 0 is never forwarded. Load-use hazards are handled upstream.

Operand selection:
- B = `ALUSrc_i` ? `Sign_extend_i` : forwarded RT.
- `WBaddr` = `RegDst_i` ? `RDaddr_i` : `RTaddr_i`.

ALU function:
- `ALUOp` 00 → add.
- `ALUOp` 01 → sub.
- `ALUOp` 11 → add (addi).
- `ALUOp` 10 → decode `funct`: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x18 mul. Any other funct value gives result 0.
- All arithmetic is 32-bit modulo; overflow is ignored. `mul` keeps the low 32 bits of the product.

Multiplier FSM (states IDLE, BUSY, DONE):
- IDLE:
  - Transition: `mul` present (`ALUOp` = 10, `funct` = 0x18) → BUSY.
  - At that edge: capture forwarded A into the multiplicand, forwarded B into the multiplier, set product = 0 and count = 0.
  - Operands must be captured here, because the forwarding sources drain while the stage is stalled.
- BUSY: each cycle, if multiplier bit 0 = 1 then add the multiplicand to the product; shift the multiplicand left 1 and the multiplier right 1; count++. When count reaches 31 (the 32nd iteration) → DONE.
- DONE: `ALUresult` selects the product; next state is IDLE unconditionally.
- `stall_o` = (IDLE and `mul` present) or BUSY.

EX/MEM register (updates every edge):
- `stall_o` = 1: load a bubble. All four control outputs = 0; `ALUresult_o`, `WriteData_o` and `WBaddr_o` hold their previous values.
- `stall_o` = 0: load the computed values.

## Timing
Reset:
- All outputs are 0 on the edge where `rst_i` = 1: all four control bits, `ALUresult_o`, `WriteData_o` and `WBaddr_o`.
- FSM returns to IDLE; count, product and operand registers are cleared.
- `stall_o` = 0 from the cycle after reset.
- Reset during BUSY aborts the multiply; no result is ever written.

Latency:
- Non-`mul` instructions: 1 cycle. An instruction present in cycle T appears on the outputs after the edge ending T.
- `mul` entering EX in cycle T:
  - `stall_o` = 1 in cycles T through T+32 (33 cycles).
  - Cycle T+33 is DONE with `stall_o` = 0; the product appears on `ALUresult_o` after the edge ending T+33.
  - ID/EX holds the `mul` during the stall; DONE → IDLE prevents a re-trigger.
- A `mul` immediately following a `mul`: its IDLE detect cycle is T+34.
- While stalled, forwarding still reads `ALUresult_o`, but `RegWrite_o` = 0, so there is no stale EX/MEM forward.

## Configuration
`EX_ITER_MUL_EN`:
- Defined: iterative multiplier and FSM as above.
- Undefined: `mul` is a single-cycle combinational 32×32 product (low 32 bits); the FSM is not built; `stall_o` is tied 0. Both builds produce identical architectural results.

## Test plan
- Reset: hold `rst_i` for 2 cycles, release → all outputs 0 and `stall_o` = 0.
- R-type add: RS=5, RT=7, `funct` 0x20, `RegDst`=1, `RDaddr`=3 → next cycle `ALUresult_o`=12, `WBaddr_o`=3, `RegWrite_o`=1.
- Double hazard priority: previous instruction writes r3=12 in EX/MEM, MEM/WB also writes r3=99, next instruction is sub r4=r3−r3 → `ALUresult_o`=0 using the EX/MEM value; repeat with r0 as the destination → no forwarding.
- sw path: `ALUOp` 00, `ALUSrc`=1, imm=0xFFFFFFFC, RS=0x100, RT forwarded from MEM/WB = 0xDEAD → `ALUresult_o`=0xFC, `WriteData_o`=0xDEAD, `Memory_write_o`=1.
- Multiply (macro defined): mul 0xFFFFFFFF × 3 → `stall_o` high exactly 33 cycles with bubble control outputs; then `ALUresult_o`=0xFFFFFFFD. Same stimulus with the macro undefined → result next cycle and no stall.
- Reset mid-multiply: assert `rst_i` at BUSY iteration 10 → outputs 0, `stall_o` 0 next cycle, no product is written.
